// File: rtl/wrapper.sv
// SPI slave with an internal MEM_DEPTH x 8 single-port RAM.
// Ports: clk, rst_n (async, active-high), MOSI, SS_n (active low) in; MISO out.
module wrapper #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic MOSI,
    input  logic SS_n,
    output logic MISO
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [9:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       rd_addr_done_q, rd_addr_done_d;
    logic       ss_seen_q, ss_seen_d;
    logic       miso_q, miso_d;
    logic [6:0] tx_sh_q, tx_sh_d;
    logic [3:0] tx_cnt_q, tx_cnt_d;

    logic [ADDR_SIZE-1:0] wr_addr_q, rd_addr_q, pay_addr;
    logic [7:0]           tx_data_q;
    logic                 tx_valid_q;
    logic [7:0]           mem_q [MEM_DEPTH];

    assign MISO = miso_q;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q        <= IDLE;
            bit_cnt_q      <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            rd_addr_done_q <= 1'b0;
            ss_seen_q      <= 1'b0;
            miso_q         <= 1'b0;
            tx_sh_q        <= '0;
            tx_cnt_q       <= '0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            rd_addr_done_q <= rd_addr_done_d;
            ss_seen_q      <= ss_seen_d;
            miso_q         <= miso_d;
            tx_sh_q        <= tx_sh_d;
            tx_cnt_q       <= tx_cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        rd_addr_done_d = rd_addr_done_q;
        // A frame may only start after SS_n has been seen high since reset.
        ss_seen_d      = ss_seen_q | SS_n;
        miso_d         = 1'b0;
        tx_sh_d        = tx_sh_q;
        tx_cnt_d       = tx_cnt_q;

        if (tx_cnt_q != 4'd0) begin
            miso_d   = tx_sh_q[6];
            tx_sh_d  = {tx_sh_q[5:0], 1'b0};
            tx_cnt_d = tx_cnt_q - 4'd1;
        end
        if (tx_valid_q && state_q == READ_DATA) begin
            miso_d   = tx_data_q[7];
            tx_sh_d  = tx_data_q[6:0];
            tx_cnt_d = 4'd7;
        end

        unique case (state_q)
            IDLE: begin
                if (!SS_n && ss_seen_q) begin
                    state_d   = CHK_CMD;
                    bit_cnt_d = '0;
                end
            end
            CHK_CMD: begin
                if (!SS_n) begin
                    rx_data_d = {9'd0, MOSI};
                    bit_cnt_d = '0;
                    if (!MOSI)
                        state_d = WRITE;
                    else if (rd_addr_done_q)
                        state_d = READ_DATA;
                    else
                        state_d = READ_ADD;
                end
            end
            WRITE, READ_ADD, READ_DATA: begin
                if (!SS_n && bit_cnt_q != 4'd9) begin
                    rx_data_d = {rx_data_q[8:0], MOSI};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd8) begin
                        rx_valid_d = 1'b1;
                        // The read state, not b8, decides which read
                        // command the RAM sees.
                        if (state_q == READ_ADD) begin
                            rx_data_d[9:8] = 2'b10;
                            rd_addr_done_d = 1'b1;
                        end
                        if (state_q == READ_DATA) begin
                            rx_data_d[9:8] = 2'b11;
                            rd_addr_done_d = 1'b0;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (SS_n) begin
            state_d    = IDLE;
            bit_cnt_d  = '0;
            rx_valid_d = 1'b0;
            miso_d     = 1'b0;
            tx_cnt_d   = '0;
        end
    end

    assign pay_addr = ADDR_SIZE'(32'(rx_data_q[7:0]) % 32'(MEM_DEPTH));

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            tx_valid_q <= 1'b0;
            if (rx_valid_q) begin
                unique case (rx_data_q[9:8])
                    2'b00: wr_addr_q <= pay_addr;
                    2'b01: ;
                    2'b10: rd_addr_q <= pay_addr;
                    2'b11: begin
                        tx_data_q  <= mem_q[rd_addr_q];
                        tx_valid_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (rx_valid_q && rx_data_q[9:8] == 2'b01)
            mem_q[wr_addr_q] <= rx_data_q[7:0];
    end

endmodule

// File: tb/tb_wrapper.sv
// Randomised self-checking bench for the SPI slave + RAM wrapper.
// A transaction-level memory model predicts MISO bytes and RAM contents.
module tb_wrapper;

    localparam int ST_IDLE = 0;

    logic clk = 1'b0;
    logic rst_n, MOSI, SS_n, MISO;

    wrapper dut (
        .clk  (clk),
        .rst_n(rst_n),
        .MOSI (MOSI),
        .SS_n (SS_n),
        .MISO (MISO)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int rxv_cnt = 0;

    logic [7:0] m_mem [256];
    logic       m_kn  [256];
    logic [7:0] m_wa, m_ra;
    logic       m_done;
    int         m_rxv;
    logic       pre;

    always @(negedge clk)
        if (dut.rx_valid_q === 1'b1) rxv_cnt++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [9:0] f, output logic rd,
                         output logic [7:0] b, output logic kn);
        logic [1:0] c;
        rd = 1'b0;
        b  = 8'h00;
        kn = 1'b1;
        if (!f[9]) c = f[9:8];
        else       c = m_done ? 2'b11 : 2'b10;
        m_rxv++;
        case (c)
            2'b00: m_wa = f[7:0];
            2'b01: begin
                m_mem[m_wa] = f[7:0];
                m_kn[m_wa]  = 1'b1;
            end
            2'b10: begin
                m_ra   = f[7:0];
                m_done = 1'b1;
            end
            default: begin
                rd     = 1'b1;
                b      = m_mem[m_ra];
                kn     = m_kn[m_ra];
                m_done = 1'b0;
            end
        endcase
    endtask

    task automatic send_bits(input logic [9:0] f, input int n);
        @(negedge clk);
        SS_n = 1'b0;
        MOSI = 1'($urandom_range(0, 1));
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            pre |= (MISO !== 1'b0);
            MOSI = f[9-i];
        end
    endtask

    task automatic frame(input logic [9:0] f, input int h,
                         output logic [15:0] s, output logic post);
        s = '0;
        send_bits(f, 10);
        for (int j = 0; j < h; j++) begin
            @(negedge clk);
            s[j] = MISO;
            MOSI = 1'($urandom_range(0, 1));
        end
        SS_n = 1'b1;
        @(negedge clk);
        post = (MISO !== 1'b0);
    endtask

    task automatic do_frame(input logic [9:0] f, input int h,
                            input string tag);
        logic [15:0] s, ev, mk;
        logic post, rd, kn;
        logic [7:0] b;
        pre = 1'b0;
        model(f, rd, b, kn);
        frame(f, h, s, post);
        ev = '0;
        mk = 16'((32'd1 << h) - 32'd1);
        if (rd)
            for (int j = 2; j < 10; j++) ev[j] = b[9-j];
        if (rd && !kn) mk[9:2] = '0;
        chk({tag, "_miso"}, 32'(s & mk), 32'(ev & mk));
        chk({tag, "_quiet"}, {30'd0, pre, post}, 32'd0);
        chk({tag, "_rxv"}, rxv_cnt, m_rxv);
        chk({tag, "_done"}, 32'(dut.rd_addr_done_q), 32'(m_done));
    endtask

    task automatic do_abort(input logic [9:0] f, input int n,
                            input string tag);
        pre = 1'b0;
        send_bits(f, n);
        @(negedge clk);
        SS_n = 1'b1;
        @(negedge clk);
        chk({tag, "_state"}, 32'(dut.state_q), ST_IDLE);
        chk({tag, "_rxv"}, rxv_cnt, m_rxv);
        chk({tag, "_quiet"}, {31'd0, pre}, 32'd0);
    endtask

    initial begin
        int op;
        logic [7:0] p;
        logic [9:0] f;
        rst_n  = 1'b1;
        SS_n   = 1'b1;
        MOSI   = 1'b0;
        m_wa   = '0;
        m_ra   = '0;
        m_done = 1'b0;
        m_rxv  = 0;
        for (int i = 0; i < 256; i++) begin
            m_mem[i] = '0;
            m_kn[i]  = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk("rst_miso", 32'(MISO), 32'd0);
        chk("rst_rxv", 32'(dut.rx_valid_q), 32'd0);
        chk("rst_done", 32'(dut.rd_addr_done_q), 32'd0);
        chk("rst_txv", 32'(dut.tx_valid_q), 32'd0);
        chk("rst_wa", 32'(dut.wr_addr_q), 32'd0);
        chk("rst_ra", 32'(dut.rd_addr_q), 32'd0);
        chk("rst_state", 32'(dut.state_q), ST_IDLE);
        chk("rst_cnt", 32'(dut.bit_cnt_q), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);

        do_frame(10'b00_1111_1111, 12, "wr_addr");
        do_frame(10'b01_1010_0101, 12, "wr_data");
        chk("mem_ff", 32'(dut.mem_q[8'hFF]), 32'hA5);
        do_frame(10'b10_1111_1111, 12, "rd_addr");
        do_frame(10'b11_0000_0000, 12, "rd_data");

        do_frame({2'b00, 8'h10}, 12, "wa10");
        do_frame({2'b01, 8'h5A}, 12, "wd10");
        do_frame({2'b11, 8'h10}, 12, "route");
        chk("route_ra", 32'(dut.rd_addr_q), 32'h10);
        do_frame({2'b11, 8'h00}, 12, "route_rd");

        do_abort({2'b01, 8'h33}, 5, "abort");
        chk("abort_mem", 32'(dut.mem_q[8'h10]), 32'h5A);

        do_frame({2'b10, 8'hFF}, 12, "ss_ra");
        do_frame({2'b11, 8'h00}, 5, "ss_stop");

        do_frame({2'b00, 8'h00}, 12, "wrap_wa0");
        do_frame({2'b01, 8'h3C}, 12, "wrap_wd0");
        do_frame({2'b00, 8'hFF}, 12, "wrap_waf");
        do_frame({2'b01, 8'h7E}, 12, "wrap_wdf");
        do_frame({2'b10, 8'h00}, 12, "wrap_ra0");
        do_frame({2'b11, 8'h00}, 12, "wrap_rd0");
        do_frame({2'b10, 8'hFF}, 12, "wrap_raf");
        do_frame({2'b11, 8'h00}, 12, "wrap_rdf");

        do_frame({2'b10, 8'hFF}, 12, "ar_ra");
        send_bits({2'b11, 8'h00}, 10);
        m_rxv++;
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        chk("ar_miso", 32'(MISO), 32'd0);
        chk("ar_state", 32'(dut.state_q), ST_IDLE);
        chk("ar_done", 32'(dut.rd_addr_done_q), 32'd0);
        chk("ar_wa", 32'(dut.wr_addr_q), 32'd0);
        m_wa   = '0;
        m_ra   = '0;
        m_done = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            MOSI = 1'($urandom_range(0, 1));
        end
        chk("ar_hold_state", 32'(dut.state_q), ST_IDLE);
        chk("ar_hold_rxv", rxv_cnt, m_rxv);
        SS_n = 1'b1;
        @(negedge clk);
        chk("ar_mem_keep", 32'(dut.mem_q[8'hFF]), 32'h7E);

        for (int it = 0; it < 60; it++) begin
            op = int'($urandom_range(0, 5));
            p  = 8'($urandom);
            if ((op == 0 || op == 2) && $urandom_range(0, 3) != 0) begin
                case ($urandom_range(0, 3))
                    0: p = 8'h00;
                    1: p = 8'h01;
                    2: p = 8'hFE;
                    default: p = 8'hFF;
                endcase
            end
            case (op)
                0: f = {2'b00, p};
                1: f = {2'b01, p};
                2: f = {2'b10, p};
                default: f = {2'b11, p};
            endcase
            if (op == 5) begin
                do_abort({2'($urandom), p}, int'($urandom_range(1, 9)),
                         "rnd_abort");
            end else begin
                do_frame(f, ($urandom_range(0, 3) == 0) ? 5 : 12, "rnd");
                if (op == 1)
                    chk("rnd_mem", 32'(dut.mem_q[m_wa]), 32'(m_mem[m_wa]));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wrapper.md
WRAPPER -- requirements
Module: wrapper

Interface
REQ-001 Parameters: MEM_DEPTH, default 256, RAM word count; ADDR_SIZE, default 8, RAM address width.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-high (rst_n=1 resets regardless of clk).
REQ-004 MOSI  input  1  serial data in, sampled on clk rising edge, MSB first.
REQ-005 SS_n  input  1  slave select, active low; high ends or aborts any frame.
REQ-006 MISO  output  1  serial data out, registered, MSB first.

Function
REQ-007 Block SHALL contain an SPI slave FSM and a MEM_DEPTH x 8 single-port RAM, linked internally by rx_data[9:0], rx_valid, tx_data[7:0], tx_valid.
REQ-008 Frame SHALL be 10 bits, b9..b0. b9:b8 = command: 00 write-address, 01 write-data, 10 read-address, 11 read-data. b7:b0 = payload.
REQ-009 FSM states SHALL be IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
REQ-010 IDLE: SS_n=0 at edge -> CHK_CMD; else stay.
REQ-011 CHK_CMD edge: SS_n=1 -> IDLE. Else MOSI is sampled as b9 and stored. MOSI=0 -> WRITE. MOSI=1 with rd_addr_done=0 -> READ_ADD. MOSI=1 with rd_addr_done=1 -> READ_DATA.
REQ-012 In WRITE, READ_ADD and READ_DATA, the next 9 edges SHALL shift b8..b0 into rx_data MSB first.
REQ-013 On the edge capturing b0, rx_data SHALL be complete and rx_valid SHALL be high for exactly the following cycle.
REQ-014 MOSI bits after b0 SHALL be ignored until SS_n returns high.
REQ-015 Any state with SS_n=1 at an edge SHALL go to IDLE and clear the bit counter. A partial frame SHALL produce no rx_valid and no RAM action.
REQ-016 rd_addr_done SHALL set when a READ_ADD frame completes and clear when a READ_DATA frame completes.
REQ-017 RAM acts on the edge where rx_valid=1:
- 00: wr_addr <= payload.
- 01: mem[wr_addr] <= payload.
- 10: rd_addr <= payload.
- 11: tx_data <= mem[rd_addr], tx_valid high for one cycle.
REQ-018 RAM SHALL ignore rx_data when rx_valid=0. Addresses SHALL wrap modulo MEM_DEPTH. Addresses SHALL persist across frames.
REQ-019 READ_DATA output, with b0 captured at edge k:
- tx_valid is high during cycle k+1..k+2.
- MISO = tx_data[7] after edge k+2.
- MISO = tx_data[0] after edge k+9.
- MISO = 0 after edge k+10.
- State SHALL remain READ_DATA until SS_n=1.
REQ-020 MISO SHALL be 0 whenever not shifting read data.
REQ-021 SS_n rising during MISO shifting SHALL stop shifting: MISO = 0 at next edge, state -> IDLE.

Reset
REQ-022 rst_n=1 SHALL asynchronously force:
- state = IDLE
- bit counter, rx_data, rx_valid = 0
- rd_addr_done = 0
- wr_addr, rd_addr, tx_data, tx_valid = 0
- MISO = 0
REQ-023 RAM array contents SHALL NOT be reset.
REQ-024 Reset asserted mid-frame SHALL discard the frame. After reset releases, SS_n must go high then low before a new frame starts.

Verification
REQ-025 Write path: frame 00_1111_1111 (address 0xFF), SS_n high, frame 01_1010_0101 -> mem[0xFF] = 0xA5, MISO stays 0 throughout.
REQ-026 Read path: after REQ-025, frame 10_1111_1111, SS_n high, frame 11_0000_0000 -> MISO = 1,0,1,0,0,1,0,1 on edges k+2..k+9, then 0.
REQ-027 Command routing: a read-data command before any read-address -> FSM enters READ_ADD (rd_addr_done=0) and rd_addr is updated; no MISO activity.
REQ-028 Abort: SS_n high after 5 bits of frame 01_xxxx -> no rx_valid, memory unchanged, FSM in IDLE next cycle.
REQ-029 Async reset: rst_n=1 between clock edges during READ_DATA shifting -> MISO = 0 and state = IDLE immediately; rd_addr_done = 0 afterwards.
REQ-030 Wrap and persistence: write 0x3C to address 0x00 and 0x7E to address 0xFF, then read both -> 0x3C and 0x7E returned in order.
